// File: rtl/chan_fifo_sink_pkg.sv
// Shared widths and helpers for the host-channel FIFO sink.
package chan_fifo_sink_pkg;

    localparam int CHAN_W  = 7;
    localparam int BYTE_W  = 8;
    localparam int CKSUM_W = 16;

    // Occupancy reported to the host, clamped to one byte (only 256 overflows).
    function automatic logic [BYTE_W-1:0] sat_occ(input logic [8:0] cnt);
        return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/fifo_fwft.sv
// Generic first-word-fall-through FIFO; head is valid whenever empty is low.
module fifo_fwft #(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from the next count so downstream decode sees clean state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/chan_fifo_sink.sv
// Host-channel FIFO sink: buffers host writes on one channel for a valid/ready consumer.
// Optional running checksum of popped bytes enabled by CHAN_FIFO_SINK_CKSUM_EN.
module chan_fifo_sink
    import chan_fifo_sink_pkg::*;
#(
    parameter logic [CHAN_W-1:0] CHAN_ADDR  = 7'd0,
    parameter int                DEPTH_LOG2 = 4
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [CHAN_W-1:0]   chanAddr_in,
    input  logic [BYTE_W-1:0]   h2fData_in,
    input  logic                h2fValid_in,
    output logic                h2fReady_out,
    output logic [BYTE_W-1:0]   f2hData_out,
    output logic                f2hValid_out,
    input  logic                f2hReady_in,
    output logic [BYTE_W-1:0]   dataOut,
    output logic                validOut,
    input  logic                readyIn,
    output logic [CKSUM_W-1:0]  checksum_out
);
    logic                addressed;
    logic                push, pop;
    logic                full, empty;
    logic [DEPTH_LOG2:0] count;
    logic                unused_f2h_ready;

    assign addressed = (chanAddr_in == CHAN_ADDR);
    assign push      = addressed && h2fValid_in && !full;
    assign pop       = validOut && readyIn;

    fifo_fwft #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (BYTE_W)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (reset_in),
        .push  (push),
        .pop   (pop),
        .din   (h2fData_in),
        .head  (dataOut),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign validOut     = !empty;
    assign h2fReady_out = addressed ? !full : 1'b1;
    assign f2hData_out  = addressed ? sat_occ(9'(count)) : '0;
    assign f2hValid_out = 1'b1;

    // comm_fpga's readback handshake has no effect on occupancy.
    assign unused_f2h_ready = f2hReady_in;

`ifdef CHAN_FIFO_SINK_CKSUM_EN
    logic [CKSUM_W-1:0] cksum;

    always_ff @(posedge clk_in) begin
        if (reset_in)  cksum <= '0;
        else if (pop)  cksum <= cksum + CKSUM_W'(dataOut);
    end

    assign checksum_out = cksum;
`else
    assign checksum_out = '0;
`endif

endmodule

// File: tb/tb_chan_fifo_sink.sv
// Directed + random bench for chan_fifo_sink against a queue-based reference model.
module tb_chan_fifo_sink;
    localparam logic [6:0] CHAN = 7'd0;
    localparam int DEPTH = 16;
`ifdef CHAN_FIFO_SINK_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic [6:0]  chanAddr_in = CHAN;
    logic [7:0]  h2fData_in = '0;
    logic        h2fValid_in = 1'b0;
    logic        h2fReady_out;
    logic [7:0]  f2hData_out;
    logic        f2hValid_out;
    logic        f2hReady_in = 1'b1;
    logic [7:0]  dataOut;
    logic        validOut;
    logic        readyIn = 1'b0;
    logic [15:0] checksum_out;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [15:0] cks = '0;

    always #5 clk = ~clk;

    chan_fifo_sink #(.CHAN_ADDR(CHAN), .DEPTH_LOG2(4)) dut (
        .clk_in       (clk),
        .reset_in     (reset_in),
        .chanAddr_in  (chanAddr_in),
        .h2fData_in   (h2fData_in),
        .h2fValid_in  (h2fValid_in),
        .h2fReady_out (h2fReady_out),
        .f2hData_out  (f2hData_out),
        .f2hValid_out (f2hValid_out),
        .f2hReady_in  (f2hReady_in),
        .dataOut      (dataOut),
        .validOut     (validOut),
        .readyIn      (readyIn),
        .checksum_out (checksum_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Compare every output against the model's view of the current state.
    task automatic check_state(input string tag);
        bit addr_hit;
        int occ;
        addr_hit = (chanAddr_in == CHAN);
        occ = (q.size() > 255) ? 255 : q.size();
        check({tag, ".ready"}, 16'(h2fReady_out), addr_hit ? 16'(q.size() < DEPTH) : 16'd1);
        check({tag, ".rb"},    16'(f2hData_out),  addr_hit ? 16'(occ) : 16'd0);
        check({tag, ".f2hv"},  16'(f2hValid_out), 16'd1);
        check({tag, ".valid"}, 16'(validOut),     16'(q.size() != 0));
        if (q.size() != 0) check({tag, ".data"}, 16'(dataOut), 16'(q[0]));
        check({tag, ".cksum"}, checksum_out, CK_EN ? cks : 16'h0);
    endtask

    // One clock: drive inputs, check pre-edge outputs, advance model at the edge.
    task automatic cyc(input string tag, input logic rst, input logic [6:0] a,
                       input logic v, input logic [7:0] d, input logic r);
        bit do_push, do_pop;
        reset_in = rst; chanAddr_in = a; h2fValid_in = v; h2fData_in = d; readyIn = r;
        #1;
        check_state(tag);
        do_push = (a == CHAN) && v && (q.size() < DEPTH);
        do_pop  = (q.size() != 0) && r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cks = '0;
        end else begin
            if (do_pop) begin
                cks = cks + 16'(q[0]);
                void'(q.pop_front());
            end
            if (do_push) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_in = 1'b0;
        q.delete();
        cks = '0;
        check_state("reset");
        check("reset_rb", 16'(f2hData_out), 16'h0);

        // Fill
        for (int i = 1; i <= 16; i++) cyc("fill", 0, CHAN, 1, 8'(i), 0);
        check("full_ready", 16'(h2fReady_out), 16'd0);
        check("full_rb", 16'(f2hData_out), 16'h10);
        cyc("push17", 0, CHAN, 1, 8'hAA, 0);
        check("still_full_rb", 16'(f2hData_out), 16'h10);

        // Drain order
        for (int i = 1; i <= 16; i++) begin
            check("drain_order", 16'(dataOut), 16'(i));
            cyc("drain", 0, CHAN, 0, 8'h00, 1);
        end
        check("drained_valid", 16'(validOut), 16'd0);
        check("drained_rb", 16'(f2hData_out), 16'h0);

        // Concurrent push/pop at count=1
        cyc("c55", 0, CHAN, 1, 8'h55, 0);
        cyc("c66", 0, CHAN, 1, 8'h66, 1);
        check("conc_rb", 16'(f2hData_out), 16'h1);
        check("conc_data", 16'(dataOut), 16'h66);
        cyc("cpop", 0, CHAN, 0, 8'h00, 1);

        // Unaddressed traffic
        for (int i = 0; i < 5; i++) cyc("unaddr", 0, CHAN + 7'd1, 1, 8'(8'hC0 + i), 0);
        check("unaddr_ready", 16'(h2fReady_out), 16'd1);
        check("unaddr_rb", 16'(f2hData_out), 16'h0);
        cyc("unaddr_back", 0, CHAN, 0, 8'h00, 0);
        check("unaddr_cnt", 16'(f2hData_out), 16'h0);

        // Reset mid-stream, with push/pop asserted in the reset cycle
        for (int i = 0; i < 3; i++) cyc("pre_rst", 0, CHAN, 1, 8'(8'h30 + i), 0);
        cyc("rst", 1, CHAN, 1, 8'hEE, 1);
        check("rst_valid", 16'(validOut), 16'd0);
        check("rst_rb", 16'(f2hData_out), 16'h0);
        check("rst_ready", 16'(h2fReady_out), 16'd1);
        cyc("p77", 0, CHAN, 1, 8'h77, 0);
        check("p77_data", 16'(dataOut), 16'h77);
        check("p77_valid", 16'(validOut), 16'd1);

        // Checksum: 257 x 0xFF, then 0x01
        cyc("ck_rst", 1, CHAN, 0, 8'h00, 0);
        for (int i = 0; i < 257; i++) cyc("ck_ff", 0, CHAN, 1, 8'hFF, 1);
        cyc("ck_last", 0, CHAN, 1, 8'h01, 1);
        check("cksum_257", checksum_out, CK_EN ? 16'hFFFF : 16'h0);
        cyc("ck_01", 0, CHAN, 0, 8'h00, 1);
        check("cksum_wrap", checksum_out, 16'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? CHAN + 7'd1 : CHAN;
            cyc("rand", $urandom_range(0, 79) == 0, a, 1'($urandom),
                8'($urandom), $urandom_range(0, 2) == 0);
        end
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chan_fifo_sink.md
Name: chan_fifo_sink

Overview:
- Downstream consumer of the comm_fpga host>>FPGA channel pipe.
- Captures host writes addressed to one channel into a first-word-fall-through (FWFT) FIFO and presents them to application logic on a valid/ready stream.
- Answers host reads on the same channel with the current FIFO occupancy.
- Sits between comm_fpga and user logic in top_level, replacing the always-ready register channels with proper back-pressure.

Parameters:
- CHAN_ADDR, 7'd0: channel address this block owns.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes. Legal range 1..8.

Ports:
- clk_in  input  1  system clock (fx2Clk_in domain).
- reset_in  input  1  synchronous, active-high reset.
- chanAddr_in  input  7  currently selected channel from comm_fpga.
- h2fData_in  input  8  host write data.
- h2fValid_in  input  1  host byte present this cycle.
- h2fReady_out  output  1  block can accept a host byte.
- f2hData_out  output  8  readback byte for host reads.
- f2hValid_out  output  1  readback byte available.
- f2hReady_in  input  1  comm_fpga consuming readback byte (no internal effect).
- dataOut  output  8  FIFO head byte to application.
- validOut  output  1  FIFO non-empty.
- readyIn  input  1  application pops head when high with validOut.
- checksum_out  output  16  running sum of popped bytes (optional feature).

Behaviour:
- Host accept: push = (chanAddr_in == CHAN_ADDR) && h2fValid_in && !full. The byte is written at that clock edge.
- h2fReady_out = !full when chanAddr_in == CHAN_ADDR, else 1. Combinational from chanAddr_in and the registered full flag.
- Host bytes presented while full are not written and not counted. comm_fpga holds them, because ready is low.
- Pop: pop = validOut && readyIn. Head advances at that edge.
- validOut = (count != 0), registered state. dataOut = mem[rdPtr].
- Latency: byte pushed at edge N appears on dataOut/validOut in the cycle after edge N. There is no same-cycle bypass when empty.
- Pointers: wrPtr and rdPtr are DEPTH_LOG2 bits and wrap modulo depth. count is DEPTH_LOG2+1 bits, range 0..2**DEPTH_LOG2.
- full = (count == 2**DEPTH_LOG2).
- Count update per edge:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Simultaneous push and pop when count==1: both occur. The new byte becomes the head next cycle.
- When full, pop may proceed. A push in the same cycle is blocked because ready is low, so count goes to depth-1.
- Readback:
  - f2hData_out = occupancy saturated to 8'hFF (only reachable at DEPTH_LOG2=8, count 256) when chanAddr_in == CHAN_ADDR.
  - Otherwise f2hData_out = 8'h00.
  - f2hValid_out = 1 always.
  - f2hData_out is combinational from registered count.
- Reset (synchronous, reset_in high at edge):
  - wrPtr=0, rdPtr=0, count=0.
  - validOut=0, h2fReady_out=1 (when addressed), f2hData_out=0x00, checksum_out=0.
  - Memory contents are not reset.
- Reset mid-stream: all buffered bytes are discarded. Push or pop in the reset cycle is ignored.
- Channel switch: it is legal on any cycle. The block ignores h2fValid_in when not addressed.

Optional Feature:
- CHAN_FIFO_SINK_CKSUM_EN defined:
  - 16-bit register adds zero-extended dataOut on every pop, wrapping modulo 2**16.
  - Cleared by reset.
  - Driven on checksum_out, which the top level feeds to seven_seg.
- Not defined: checksum_out is tied to 16'h0000 and no adder or register is built.

Decomposition:
- Shared package holds:
  - channel-address width constant (7);
  - byte width constant (8);
  - checksum width constant (16);
  - function computing saturated 8-bit occupancy from a count.
- One natural sub-module: fifo_fwft, a generic FWFT FIFO that takes DEPTH_LOG2 and exposes push, pop, head, count, full and empty.
- chan_fifo_sink holds:
  - address decode;
  - the ready/valid mapping;
  - readback;
  - the optional checksum.

Test Plan:
- Fill: DEPTH_LOG2=4, addressed, push 0x01..0x10, readyIn=0.
  - After 16 pushes h2fReady_out=0 and readback=0x10.
  - A 17th byte 0xAA is not accepted.
- Drain order: from the full state raise readyIn.
  - dataOut sequence is 0x01..0x10 on consecutive cycles.
  - validOut drops the cycle after the 16th pop. Readback=0x00.
- Concurrent push/pop at count=1 (head 0x55): push 0x66 and pop in the same cycle.
  - Next cycle count=1 and dataOut=0x66.
- Unaddressed traffic: chanAddr_in=CHAN_ADDR+1 with h2fValid_in=1 for 5 cycles.
  - count stays 0, h2fReady_out=1, f2hData_out=0x00.
- Reset mid-stream: 3 bytes buffered, then reset_in=1 for one cycle.
  - validOut=0, readback=0x00, h2fReady_out=1.
  - The next push 0x77 appears on dataOut one cycle later.
- CHAN_FIFO_SINK_CKSUM_EN: push and pop 0xFF 257 times.
  - checksum_out = (257*255) mod 65536 = 0xFFFF.
  - One more pop of 0x01 gives 0x0000.
